// File: rtl/traffic_pkg.sv
// traffic_pkg: shared types and constants for the intersection phase sequencer.
//   - state_e        : 3-bit phase state encoding (code 3'd7 is illegal)
//   - LAMP_*         : one-hot lamp codes, [2]=red [1]=yellow [0]=green
//   - *_END          : counter value on which each phase is left
//   - CNT_W          : phase counter width
//   - main_lamp/side_lamp : lamp decode of a state (unknown states -> red)
//   - count_in_range : checks that a counter value belongs to a state
// Optional feature macro: TRAFFIC_PED_EN (pedestrian walk phase).
package traffic_pkg;

  localparam int CNT_W = 6;

  typedef enum logic [2:0] {
    MAIN_GREEN  = 3'd0,
    MAIN_YELLOW = 3'd1,
    ALL_RED_A   = 3'd2,
    SIDE_GREEN  = 3'd3,
    SIDE_YELLOW = 3'd4,
    ALL_RED_B   = 3'd5,
    PED_WALK    = 3'd6
  } state_e;

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;

  localparam logic [CNT_W-1:0] MG_END  = 6'd11;
  localparam logic [CNT_W-1:0] MY_END  = 6'd13;
  localparam logic [CNT_W-1:0] ARA_END = 6'd15;
  localparam logic [CNT_W-1:0] SG_END  = 6'd26;
  localparam logic [CNT_W-1:0] SY_END  = 6'd28;
  localparam logic [CNT_W-1:0] ARB_END = 6'd30;
  localparam logic [CNT_W-1:0] PW_END  = 6'd40;

  // Main-road lamp for a state; anything not explicitly green/yellow is red.
  function automatic logic [2:0] main_lamp(input state_e s);
    logic [2:0] lamp;
    case (s)
      MAIN_GREEN:  lamp = LAMP_GRN;
      MAIN_YELLOW: lamp = LAMP_YEL;
      default:     lamp = LAMP_RED;
    endcase
    return lamp;
  endfunction

  // Side-road lamp for a state; anything not explicitly green/yellow is red.
  function automatic logic [2:0] side_lamp(input state_e s);
    logic [2:0] lamp;
    case (s)
      SIDE_GREEN:  lamp = LAMP_GRN;
      SIDE_YELLOW: lamp = LAMP_YEL;
      default:     lamp = LAMP_RED;
    endcase
    return lamp;
  endfunction

  // True when the counter lies inside the window owned by the state.
  // Illegal encodings (and PED_WALK when the feature is absent) never match.
  function automatic logic count_in_range(input state_e s, input logic [CNT_W-1:0] c);
    logic ok;
    case (s)
      MAIN_GREEN:  ok = (c <= MG_END);
      MAIN_YELLOW: ok = (c > MG_END)  && (c <= MY_END);
      ALL_RED_A:   ok = (c > MY_END)  && (c <= ARA_END);
      SIDE_GREEN:  ok = (c > ARA_END) && (c <= SG_END);
      SIDE_YELLOW: ok = (c > SG_END)  && (c <= SY_END);
      ALL_RED_B:   ok = (c > SY_END)  && (c <= ARB_END);
`ifdef TRAFFIC_PED_EN
      PED_WALK:    ok = (c > ARB_END) && (c <= PW_END);
`endif
      default:     ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/traffic_sequencer_if.sv
// traffic_sequencer_if: control and lamp signals of the phase sequencer.
//   tick        : one-cycle advance strobe from the prescaler
//   ped_btn     : synchronised pedestrian button level
//   counter     : current phase count
//   main_light  : main-road lamp (one-hot red/yellow/green)
//   side_light  : side-road lamp (one-hot red/yellow/green)
//   walk        : pedestrian walk lamp
//   ped_pending : pedestrian request latched
// Modports: master drives tick/ped_btn, slave (the sequencer) drives the rest.
interface traffic_sequencer_if;
  import traffic_pkg::*;

  logic             tick;
  logic             ped_btn;
  logic [CNT_W-1:0] counter;
  logic [2:0]       main_light;
  logic [2:0]       side_light;
  logic             walk;
  logic             ped_pending;

  modport master (
    output tick, ped_btn,
    input  counter, main_light, side_light, walk, ped_pending
  );

  modport slave (
    input  tick, ped_btn,
    output counter, main_light, side_light, walk, ped_pending
  );
endinterface

// File: rtl/traffic_sequencer_ped_latch.sv
// ped_latch: set/clear flop holding the pedestrian request.
//   clk, rst : clock and asynchronous active-high reset
//   set      : request level (button)
//   clr      : clear strobe, wins over set
//   inhibit  : blocks set (asserted while the walk phase is active)
//   pending  : latched request
module ped_latch (
  input  logic clk,
  input  logic rst,
  input  logic set,
  input  logic clr,
  input  logic inhibit,
  output logic pending
);

  logic pending_r;

  // Request flop: clear has priority, set is ignored while inhibited.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_r <= 1'b0;
    end else if (clr) begin
      pending_r <= 1'b0;
    end else if (set && !inhibit) begin
      pending_r <= 1'b1;
    end else begin
      pending_r <= pending_r;
    end
  end

  assign pending = pending_r;

endmodule

// File: rtl/traffic_sequencer.sv
// traffic_sequencer: Moore phase sequencer for the intersection controller.
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   bus  : traffic_sequencer_if.slave (tick, ped_btn in; counter, lamps,
//          walk, ped_pending out)
// All outputs come straight from flops. Lamp flops are loaded with the decode
// of the next state, so they always equal the decode of the state register.
// Optional feature macro: TRAFFIC_PED_EN enables the PED_WALK phase and the
// pedestrian request latch; without it ped_btn is ignored and walk and
// ped_pending are held at 0.
module traffic_sequencer
  import traffic_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  traffic_sequencer_if.slave  bus
);

  state_e           state_r;
  state_e           state_next_s;
  logic [CNT_W-1:0] counter_r;
  logic [CNT_W-1:0] counter_next_s;
  logic [2:0]       main_light_r;
  logic [2:0]       side_light_r;

`ifdef TRAFFIC_PED_EN
  logic ped_pending_s;
  logic ped_clr_s;
  logic ped_inhibit_s;
  logic walk_r;
`else
  logic ped_btn_unused_s;
`endif

  // Next-state and next-count: only a tick moves the machine; an out-of-window
  // counter or illegal state is recovered to MAIN_GREEN with count 0.
  always_comb begin
    state_next_s   = state_r;
    counter_next_s = counter_r;
    if (bus.tick) begin
      if (!count_in_range(state_r, counter_r)) begin
        state_next_s   = MAIN_GREEN;
        counter_next_s = {CNT_W{1'b0}};
      end else begin
        case (state_r)
          MAIN_GREEN: begin
            if (counter_r == MG_END) state_next_s = MAIN_YELLOW;
            else                     state_next_s = MAIN_GREEN;
          end
          MAIN_YELLOW: begin
            if (counter_r == MY_END) state_next_s = ALL_RED_A;
            else                     state_next_s = MAIN_YELLOW;
          end
          ALL_RED_A: begin
            if (counter_r == ARA_END) state_next_s = SIDE_GREEN;
            else                      state_next_s = ALL_RED_A;
          end
          SIDE_GREEN: begin
            if (counter_r == SG_END) state_next_s = SIDE_YELLOW;
            else                     state_next_s = SIDE_GREEN;
          end
          SIDE_YELLOW: begin
            if (counter_r == SY_END) state_next_s = ALL_RED_B;
            else                     state_next_s = SIDE_YELLOW;
          end
          ALL_RED_B: begin
            if (counter_r == ARB_END) begin
`ifdef TRAFFIC_PED_EN
              if (ped_pending_s) state_next_s = PED_WALK;
              else               state_next_s = MAIN_GREEN;
`else
              state_next_s = MAIN_GREEN;
`endif
            end else begin
              state_next_s = ALL_RED_B;
            end
          end
`ifdef TRAFFIC_PED_EN
          PED_WALK: begin
            if (counter_r == PW_END) state_next_s = MAIN_GREEN;
            else                     state_next_s = PED_WALK;
          end
`endif
          default: state_next_s = MAIN_GREEN;
        endcase
        // Entering MAIN_GREEN restarts the count; every other tick counts up
        // (PED_WALK continues from 31 after ALL_RED_B's 30).
        if ((state_next_s == MAIN_GREEN) && (state_r != MAIN_GREEN)) begin
          counter_next_s = {CNT_W{1'b0}};
        end else begin
          counter_next_s = counter_r + 6'd1;
        end
      end
    end else begin
      state_next_s   = state_r;
      counter_next_s = counter_r;
    end
  end

  // State, counter and lamp registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= MAIN_GREEN;
      counter_r    <= {CNT_W{1'b0}};
      main_light_r <= LAMP_GRN;
      side_light_r <= LAMP_RED;
    end else begin
      state_r      <= state_next_s;
      counter_r    <= counter_next_s;
      main_light_r <= main_lamp(state_next_s);
      side_light_r <= side_lamp(state_next_s);
    end
  end

  assign bus.counter    = counter_r;
  assign bus.main_light = main_light_r;
  assign bus.side_light = side_light_r;

`ifdef TRAFFIC_PED_EN
  // Clear the request exactly on the tick that enters the walk phase.
  assign ped_clr_s     = bus.tick && (state_r == ALL_RED_B) && (state_next_s == PED_WALK);
  assign ped_inhibit_s = (state_r == PED_WALK);

  ped_latch u_ped_latch (
    .clk     (clk),
    .rst     (rst),
    .set     (bus.ped_btn),
    .clr     (ped_clr_s),
    .inhibit (ped_inhibit_s),
    .pending (ped_pending_s)
  );

  // Walk lamp register, loaded with the decode of the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      walk_r <= 1'b0;
    end else begin
      walk_r <= (state_next_s == PED_WALK);
    end
  end

  assign bus.walk        = walk_r;
  assign bus.ped_pending = ped_pending_s;
`else
  assign ped_btn_unused_s = bus.ped_btn;
  assign bus.walk         = 1'b0;
  assign bus.ped_pending  = 1'b0;
`endif

endmodule

// File: tb/tb_traffic_sequencer.sv
// Self-checking bench for traffic_sequencer. The reference model tracks only
// the phase count and the pending request; lamps are derived from the count
// windows of the phase table.
module tb_traffic_sequencer;

`ifdef TRAFFIC_PED_EN
  localparam bit PED_EN = 1'b1;
`else
  localparam bit PED_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   m_cnt;
  bit   m_pend;

  traffic_sequencer_if bus ();

  traffic_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       tick;
    logic [5:0] cnt;
    logic [2:0] main;
    logic [2:0] side;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [2:0] e_main(input int c);
    if (c <= 11)      return 3'b001;
    else if (c <= 13) return 3'b010;
    else              return 3'b100;
  endfunction

  function automatic logic [2:0] e_side(input int c);
    if (c >= 16 && c <= 26)      return 3'b001;
    else if (c >= 27 && c <= 28) return 3'b010;
    else                         return 3'b100;
  endfunction

  // One clock cycle with the given inputs; model advances on the same edge.
  task automatic drive(input bit t, input bit b);
    int  c;
    bit  enter_walk;
    bus.tick    = t;
    bus.ped_btn = b;
    @(posedge clk);
    c = m_cnt;
    enter_walk = 1'b0;
    if (t) begin
      if (c == 30) begin
        if (PED_EN && m_pend) begin
          m_cnt = 31;
          enter_walk = 1'b1;
        end else begin
          m_cnt = 0;
        end
      end else if (c == 40) begin
        m_cnt = 0;
      end else begin
        m_cnt = c + 1;
      end
    end
    if (PED_EN) begin
      if (enter_walk)          m_pend = 1'b0;
      else if (b && c < 31)    m_pend = 1'b1;
    end
    #1;
  endtask

  task automatic check_model(input string name);
    chk({name, "_cnt"},  {2'b00, bus.counter},    8'(m_cnt));
    chk({name, "_main"}, {5'b0, bus.main_light},  {5'b0, e_main(m_cnt)});
    chk({name, "_side"}, {5'b0, bus.side_light},  {5'b0, e_side(m_cnt)});
    chk({name, "_walk"}, {7'b0, bus.walk},        {7'b0, (PED_EN && m_cnt >= 31)});
    chk({name, "_pend"}, {7'b0, bus.ped_pending}, {7'b0, m_pend});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.tick = 1'b0;
    bus.ped_btn = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    m_cnt = 0;
    m_pend = 1'b0;
  endtask

  initial begin
    int period;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.tick = 1'b0;
    bus.ped_btn = 1'b0;

    vecs[0]  = '{1'b1, 6'd1,  3'b001, 3'b100};
    vecs[1]  = '{1'b0, 6'd1,  3'b001, 3'b100};
    vecs[2]  = '{1'b1, 6'd2,  3'b001, 3'b100};
    vecs[3]  = '{1'b1, 6'd3,  3'b001, 3'b100};
    vecs[4]  = '{1'b1, 6'd4,  3'b001, 3'b100};
    vecs[5]  = '{1'b1, 6'd5,  3'b001, 3'b100};
    vecs[6]  = '{1'b1, 6'd6,  3'b001, 3'b100};
    vecs[7]  = '{1'b1, 6'd7,  3'b001, 3'b100};
    vecs[8]  = '{1'b1, 6'd8,  3'b001, 3'b100};
    vecs[9]  = '{1'b1, 6'd9,  3'b001, 3'b100};
    vecs[10] = '{1'b1, 6'd10, 3'b001, 3'b100};
    vecs[11] = '{1'b1, 6'd11, 3'b001, 3'b100};
    vecs[12] = '{1'b1, 6'd12, 3'b010, 3'b100};
    vecs[13] = '{1'b1, 6'd13, 3'b010, 3'b100};
    vecs[14] = '{1'b0, 6'd13, 3'b010, 3'b100};
    vecs[15] = '{1'b1, 6'd14, 3'b100, 3'b100};

    // Reset state
    do_reset();
    chk("rst_cnt",  {2'b00, bus.counter},    8'd0);
    chk("rst_main", {5'b0, bus.main_light},  8'd1);
    chk("rst_side", {5'b0, bus.side_light},  8'd4);
    chk("rst_walk", {7'b0, bus.walk},        8'd0);
    chk("rst_pend", {7'b0, bus.ped_pending}, 8'd0);

    // Table: holds, back-to-back ticks 10->11->12->13, phase boundaries
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].tick, 1'b0);
      chk($sformatf("vec%0d_cnt", i),  {2'b00, bus.counter},   {2'b00, vecs[i].cnt});
      chk($sformatf("vec%0d_main", i), {5'b0, bus.main_light}, {5'b0, vecs[i].main});
      chk($sformatf("vec%0d_side", i), {5'b0, bus.side_light}, {5'b0, vecs[i].side});
    end

    // Full 31-tick cycle without a request
    do_reset();
    for (int i = 1; i <= 31; i++) begin
      drive(1'b1, 1'b0);
      check_model("cyc");
      if (i == 11) chk("cyc_t11_main", {5'b0, bus.main_light}, 8'd1);
      if (i == 12) chk("cyc_t12_main", {5'b0, bus.main_light}, 8'd2);
      if (i == 14) chk("cyc_t14_main", {5'b0, bus.main_light}, 8'd4);
      if (i == 16) chk("cyc_t16_side", {5'b0, bus.side_light}, 8'd1);
      if (i == 31) chk("cyc_t31_cnt",  {2'b00, bus.counter},   8'd0);
    end

    // One-cycle press at counter 5, then run to the end of the cycle
    do_reset();
    repeat (5) drive(1'b1, 1'b0);
    drive(1'b0, 1'b1);
    chk("ped_pulse_pend", {7'b0, bus.ped_pending}, {7'b0, PED_EN});
    drive(1'b0, 1'b0);
    for (int i = 6; i <= 41; i++) begin
      if (m_cnt == 0 && i > 6) break;
      drive(1'b1, 1'b0);
      check_model("ped");
      if (i == 31) begin
        chk("ped_t31_walk", {7'b0, bus.walk},        {7'b0, PED_EN});
        chk("ped_t31_pend", {7'b0, bus.ped_pending}, 8'd0);
      end
      if (i == 41) begin
        chk("ped_t41_cnt",  {2'b00, bus.counter},   8'd0);
        chk("ped_t41_main", {5'b0, bus.main_light}, 8'd1);
        chk("ped_t41_walk", {7'b0, bus.walk},       8'd0);
      end
    end

    // Button held: period measurement, then walk-phase inhibit and re-latch
    do_reset();
    period = 0;
    for (int i = 0; i < 60; i++) begin
      drive(1'b1, 1'b1);
      check_model("held");
      period++;
      if (bus.counter == 6'd0) break;
    end
    chk("held_period", 8'(period), PED_EN ? 8'd41 : 8'd31);
    for (int i = 0; i < 45; i++) begin
      drive(1'b1, 1'b1);
      check_model("held2");
    end

    // Asynchronous reset mid-phase (counter 20), between clock edges
    do_reset();
    repeat (20) drive(1'b1, 1'b0);
    chk("arst_pre_cnt",  {2'b00, bus.counter},   8'd20);
    chk("arst_pre_side", {5'b0, bus.side_light}, 8'd1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_cnt",  {2'b00, bus.counter},    8'd0);
    chk("arst_main", {5'b0, bus.main_light},  8'd1);
    chk("arst_side", {5'b0, bus.side_light},  8'd4);
    chk("arst_walk", {7'b0, bus.walk},        8'd0);
    chk("arst_pend", {7'b0, bus.ped_pending}, 8'd0);
    m_cnt = 0;
    m_pend = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (12) drive(1'b1, 1'b0);
    chk("arst_t12_main", {5'b0, bus.main_light}, 8'd2);
    chk("arst_t12_cnt",  {2'b00, bus.counter},   8'd12);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 999) == 0) begin
        do_reset();
      end
      drive(1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
      check_model("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
